// File: rtl/pd_pkg.sv
// pd_pkg: shared state encoding and default sizing for the phase detector.
package pd_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FB  = 2'd1,
    WAIT_REF = 2'd2
  } pd_state_e;
  localparam int PD_WIDTH_ERR = 22;
  localparam int PD_TIMEOUT   = 2 ** (PD_WIDTH_ERR - 1) - 1;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: multi-flop synchronizer with one extra history flop for rising-edge detect.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [SYNC_STAGES:0] sh_q;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= {sh_q[SYNC_STAGES-1:0], d};
  end
  assign rise = sh_q[SYNC_STAGES-1] & ~sh_q[SYNC_STAGES];
endmodule

// File: rtl/phase_detect.sv
// phase_detect: time-stamps ref/fb rising edges and emits a signed phase error with a process strobe.
module phase_detect
  import pd_pkg::*;
#(
  parameter int WIDTH_ERR   = PD_WIDTH_ERR,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 2 ** (WIDTH_ERR - 1) - 1
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        ref_in,
  input  logic                        fb_in,
  output logic signed [WIDTH_ERR-1:0] err,
  output logic                        process,
  output logic                        miss,
  output logic                        slip
);
  localparam int CW = WIDTH_ERR - 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
  pd_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [WIDTH_ERR-1:0] err_q, err_d, mag;
  logic process_q, process_d, miss_q, miss_d, slip_q, slip_d;
  logic ref_rise, fb_rise;
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .sys_clk(sys_clk), .rst_n(rst_n), .d(ref_in), .rise(ref_rise)
  );
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .sys_clk(sys_clk), .rst_n(rst_n), .d(fb_in), .rise(fb_rise)
  );
  // cnt never exceeds TIMEOUT, so the zero-extended count also covers the timeout value
  assign mag = {1'b0, cnt_q};
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    process_d = 1'b0;
    miss_d    = 1'b0;
    slip_d    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WAIT_FB: begin
          if (fb_rise) begin
            err_d     = mag;
            process_d = 1'b1;
            cnt_d     = CW'(1);
            state_d   = ref_rise ? WAIT_FB : IDLE;
          end else if (ref_rise) begin
            slip_d = 1'b1;
            cnt_d  = CW'(1);
          end else if (cnt_q == TMO) begin
            err_d     = mag;
            process_d = 1'b1;
            miss_d    = 1'b1;
            state_d   = IDLE;
          end else cnt_d = cnt_q + CW'(1);
        end
        WAIT_REF: begin
          if (ref_rise) begin
            err_d     = -mag;
            process_d = 1'b1;
            cnt_d     = CW'(1);
            state_d   = fb_rise ? WAIT_REF : IDLE;
          end else if (fb_rise) begin
            slip_d = 1'b1;
            cnt_d  = CW'(1);
          end else if (cnt_q == TMO) begin
            err_d     = -mag;
            process_d = 1'b1;
            miss_d    = 1'b1;
            state_d   = IDLE;
          end else cnt_d = cnt_q + CW'(1);
        end
        default: begin
          state_d   = IDLE;
          if (ref_rise && fb_rise) begin
            err_d     = '0;
            process_d = 1'b1;
          end else if (ref_rise || fb_rise) begin
            cnt_d   = CW'(1);
            state_d = ref_rise ? WAIT_FB : WAIT_REF;
          end
        end
      endcase
    end
  end
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= '0;
      process_q <= 1'b0;
      miss_q    <= 1'b0;
      slip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      process_q <= process_d;
      miss_q    <= miss_d;
      slip_q    <= slip_d;
    end
  end
  assign err     = err_q;
  assign process = process_q;
  assign miss    = miss_q;
  assign slip    = slip_q;
endmodule
